fusion_ctrl: RTL
================

# fusion_ctrl

Sequencing controller for one `fusion_unit`. It accepts a dot-product job consisting of a length and a bitwidth configuration. It then streams packed input/weight word pairs into the fusion unit and accumulates the unit's registered `psum` outputs into a 32-bit result. Finally it returns the result on a valid/ready port. It sits between the operand buffers/scheduler and the fusion unit, and owns the unit's `input_bitwidth`/`weight_bitwidth` configuration.

## Interface
Parameters:
- `LEN_W`, 16, width of the job length (number of 32-bit word pairs).
- `FU_LAT`, 2, cycles from operand acceptance to the corresponding `fu_psum` being valid at the controller. This is 1 cycle of operand register plus 1 cycle of fusion-unit psum register.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_len`  in  LEN_W  number of word pairs in the job.
- `cfg_in_bw`  in  3  input bitwidth code.
- `cfg_wt_bw`  in  3  weight bitwidth code.
- `abort`  in  1  synchronous job cancel.
- `busy`  out  1  high in every state except IDLE.
- `op_valid`  in  1  operand pair available.
- `op_ready`  out  1  controller accepts the operand pair.
- `op_input`  in  32  packed input word.
- `op_weight`  in  32  packed weight word.
- `fu_input_forward`  out  32  registered operand to the fusion unit.
- `fu_weight`  out  32  registered operand to the fusion unit.
- `fu_input_bitwidth`  out  3  latched configuration.
- `fu_weight_bitwidth`  out  3  latched configuration.
- `fu_psum`  in  32  signed psum from the fusion unit.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  32  signed accumulated result.
- `res_err`  out  1  job rejected because of an illegal bitwidth code.
- `res_ovf`  out  1  sticky: signed overflow occurred during accumulation.

## Operation
- Bitwidth codes: 0 = 2-bit, 1 = 4-bit, 2 = 8-bit. Codes 3–7 are illegal.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`, latch `cfg_len`, `cfg_in_bw`, `cfg_wt_bw`, clear the accumulator and `res_ovf`, and clear the issue count.
  - If either bitwidth code is illegal, go to DONE with `res_err`=1 and `res_data`=0.
  - Otherwise, if `cfg_len`=0, go to DONE with `res_data`=0.
  - Otherwise go to RUN.
- RUN:
  - `op_ready` = 1 while issued < len.
  - On a handshake (`op_valid && op_ready`), register the operands into `fu_input_forward`/`fu_weight`, increment issued, and push a 1 into a FU_LAT-deep valid shift register.
  - On cycles without a handshake, load zero into the operand registers and push a 0.
  - When the last pair is accepted, go to DRAIN.
- DRAIN: `op_ready`=0. Keep accumulating. When the valid shift register is all zero, go to DONE.
- Accumulate: whenever the shift-register output is 1, acc <= acc + `fu_psum` with two's-complement wrap. Set `res_ovf` if the operands have equal sign and the sum sign differs.
- DONE:
  - `res_valid`=1, and `res_data`/`res_err`/`res_ovf` are held stable.
  - On `res_ready`, go to IDLE.
- `fu_*_bitwidth` outputs hold the last latched configuration in every state, including IDLE.
- `abort` in RUN or DRAIN: go to IDLE the next cycle, flush the shift register, zero the operand registers, and produce no result. `abort` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `op_ready`, `res_valid`, `res_err`, `res_ovf` = 0
  - `res_data` = 0
  - `fu_input_forward`, `fu_weight` = 0
  - `fu_*_bitwidth` = 0
  - accumulator and shift register cleared
- Asserting `RST` mid-job discards everything immediately (asynchronous).
- `start` sampled at edge t puts the controller in RUN at t+1, so `op_ready` is first high in cycle t+1.
- A pair accepted at edge t appears on `fu_*` in cycle t+1. Its psum is valid in cycle t+2 and is added at edge t+2.
- Full throughput: one pair per cycle with no bubbles.
- Job latency with no stalls: the last pair is accepted at edge a, DRAIN runs until edge a+2, `res_valid` rises in cycle a+3.
- Illegal-code or length-0 start: `res_valid` is high in the cycle after the start edge.
- `res_valid` stays high until `res_ready`. If `start` is asserted in the same cycle as the DONE->IDLE transition, it is not accepted; it must be re-presented in IDLE.
- Issue counter: LEN_W bits, no wrap. The maximum job length is 2^LEN_W-1.

## Test plan
- Reset mid-RUN after 3 accepts: all outputs return to reset values. A new 2-pair job then completes normally with the correct sum.
- 8-bit/8-bit job, len=4, `op_valid` held high: four consecutive accepts. `res_valid` appears 3 cycles after the last accept, and `res_data` equals the model sum of the four psums.
- Same job with `op_valid` toggling 1,0,1,0: zero bubbles are inserted, the result is identical, and no extra psums are added.
- `cfg_in_bw`=5: DONE the next cycle with `res_err`=1 and `res_data`=0. `op_ready` never goes high.
- Psums of 0x7FFFFFF0 then 0x20: `res_data`=0x80000010 and `res_ovf`=1. `res_data` is held while `res_ready`=0 for 5 cycles.
- `abort` in DRAIN with psums in flight: IDLE the next cycle, no `res_valid`. The following job's accumulator starts from 0.

Source files
------------

// File: rtl/fusion_ctrl.sv
// fusion_ctrl: sequencing controller for one fusion_unit.
// Accepts a dot-product job (length + input/weight bitwidth codes), streams packed
// operand word pairs into the fusion unit, accumulates the returned psums into a
// 32-bit wrapping result and presents it on a valid/ready result port.
//
// Ports:
//   clk, RST                     clock, asynchronous active-high reset
//   start, cfg_len, cfg_*_bw     job request and configuration (sampled in idle)
//   abort                        cancel the running job, no result produced
//   busy                         high whenever not idle
//   op_valid/op_ready/op_*       operand pair stream
//   fu_input_forward, fu_weight  registered operands to the fusion unit
//   fu_*_bitwidth                latched bitwidth configuration
//   fu_psum                      registered psum from the fusion unit
//   res_valid/res_ready          result handshake
//   res_data, res_err, res_ovf   result, illegal-code flag, sticky overflow flag
module fusion_ctrl #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned FU_LAT = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [2:0]       cfg_in_bw,
  input  logic [2:0]       cfg_wt_bw,
  input  logic             abort,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_input,
  input  logic [31:0]      op_weight,
  output logic [31:0]      fu_input_forward,
  output logic [31:0]      fu_weight,
  output logic [2:0]       fu_input_bitwidth,
  output logic [2:0]       fu_weight_bitwidth,
  input  logic [31:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             res_ovf
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [31:0]       acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [FU_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [31:0]       in_q, in_d;
  logic [31:0]       wt_q, wt_d;
  logic [2:0]        in_bw_q, in_bw_d;
  logic [2:0]        wt_bw_q, wt_bw_d;

  logic        hs;
  logic        cfg_illegal;
  logic [31:0] sum;
  logic        sum_ovf;

  assign op_ready    = (state_q == StRun) && (issued_q < len_q);
  assign hs          = op_valid && op_ready;
  assign cfg_illegal = (cfg_in_bw > 3'd2) || (cfg_wt_bw > 3'd2);

  // Signed overflow: both addends share a sign the wrapped sum does not.
  assign sum     = acc_q + fu_psum;
  assign sum_ovf = (acc_q[31] == fu_psum[31]) && (sum[31] != acc_q[31]);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    vld_sr_d = vld_sr_q;
    in_bw_d  = in_bw_q;
    wt_bw_d  = wt_bw_q;
    // Operand registers carry zero on every cycle without a handshake.
    in_d     = '0;
    wt_d     = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = cfg_len;
          in_bw_d  = cfg_in_bw;
          wt_bw_d  = cfg_wt_bw;
          acc_d    = '0;
          ovf_d    = 1'b0;
          issued_d = '0;
          err_d    = cfg_illegal;
          if (cfg_illegal || (cfg_len == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun, StDrain: begin
        if (abort) begin
          state_d  = StIdle;
          vld_sr_d = '0;
        end else begin
          // Tag tracks which psums returning FU_LAT cycles later belong to real pairs.
          vld_sr_d    = vld_sr_q << 1;
          vld_sr_d[0] = hs;
          if (hs) begin
            in_d     = op_input;
            wt_d     = op_weight;
            issued_d = issued_q + LEN_W'(1);
          end
          if (vld_sr_q[FU_LAT-1]) begin
            acc_d = sum;
            if (sum_ovf) begin
              ovf_d = 1'b1;
            end
          end
          if ((state_q == StRun) && hs && (issued_d == len_q)) begin
            state_d = StDrain;
          end
          // Leave once the psum added on this edge was the last one in flight.
          if ((state_q == StDrain) && (vld_sr_d == '0)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_sr_q <= '0;
      in_q     <= '0;
      wt_q     <= '0;
      in_bw_q  <= '0;
      wt_bw_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      vld_sr_q <= vld_sr_d;
      in_q     <= in_d;
      wt_q     <= wt_d;
      in_bw_q  <= in_bw_d;
      wt_bw_q  <= wt_bw_d;
    end
  end

  assign busy               = (state_q != StIdle);
  assign res_valid          = (state_q == StDone);
  assign res_data           = acc_q;
  assign res_err            = err_q;
  assign res_ovf            = ovf_q;
  assign fu_input_forward   = in_q;
  assign fu_weight          = wt_q;
  assign fu_input_bitwidth  = in_bw_q;
  assign fu_weight_bitwidth = wt_bw_q;

endmodule
